johnson_phase_monitor: RTL and testbench
========================================

Name: johnson_phase_monitor

Overview:
- Downstream consumer of the 4-bit Johnson (twisted-ring) up/down counter.
- Samples the counter's q[3:0] each clk and decodes it to a 3-bit phase index.
- Checks every transition for legality and reports step, wrap and direction events, a lock status and a fault flag.
- Feeds phase-sequenced control logic and the self-test status register.

Parameters:
- LOCK_N, 4: consecutive legal moving transitions required to reach LOCKED (1..15).
- CW, 8: width of the wrap counter cyc_cnt.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  reset, asynchronous, active-high.
- jq  input  4  Johnson code from the counter, same clk domain, bit 3 = MSB.
- phase  output  3  decoded phase index 0..7.
- phase_valid  output  1  phase holds a legally decoded code.
- step  output  1  one-cycle pulse: phase moved by +1 or -1.
- dir  output  1  direction of the last move: 1 = up (+1), 0 = down (-1).
- wrap  output  1  one-cycle pulse on a legal 7->0 (up) or 0->7 (down) move.
- cyc_cnt  output  CW  count of wraps, modulo 2^CW (+1 on an up wrap, -1 on a down wrap).
- lock  output  1  FSM is in LOCKED.
- illegal  output  1  sticky flag; set by an illegal code or an illegal jump.

Behaviour:
- Decode table (jq -> phase):
  - 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7.
  - The other 8 codes are illegal.
- Pipeline:
  - Edge k captures jq into jq_r.
  - Edge k+1 updates all outputs from jq_r, compared against the current phase register.
  - Latency from jq to outputs is 2 clk. All outputs are registered; there are no combinational outputs.
- Reset (clr=1, asynchronous):
  - jq_r=0000, phase=0, phase_valid=0, step=0, dir=1, wrap=0, cyc_cnt=0, lock=0, illegal=0.
  - Internal have_prev=0; FSM returns to IDLE.
  - Reset asserted mid-operation discards everything immediately.
- Transition classes (jq_r decoded d vs registered phase p, only when have_prev=1):
  - HOLD: d==p.
  - UP: d==p+1 mod 8.
  - DOWN: d==p-1 mod 8.
  - JUMP: any other legal d.
  - BAD: jq_r is an illegal code.
- FSM states: IDLE, ACQ, LOCKED, FAULT.
  - IDLE: first legal code loads phase=d, sets phase_valid=1 and have_prev=1, moves to ACQ. No step on this edge. A BAD code here stays in IDLE with phase_valid=0 and sets illegal.
  - ACQ: UP/DOWN increments run counter rc. When rc reaches LOCK_N, go to LOCKED. HOLD leaves rc unchanged. JUMP or BAD goes to FAULT.
  - LOCKED: HOLD/UP/DOWN stay in LOCKED. JUMP or BAD goes to FAULT.
  - FAULT: phase_valid=0, lock=0, rc=0. The next legal code reloads phase and goes to ACQ without a step. BAD stays in FAULT.
- Event outputs:
  - step=1 for exactly one cycle on each UP/DOWN; dir updated on the same edge.
  - wrap=1 with step on UP 7->0 or DOWN 0->7; cyc_cnt adjusts on the same edge, wrapping modulo 2^CW with no saturation.
  - HOLD produces no pulses.
  - JUMP/BAD produce no step or wrap; phase keeps its last value.
- illegal:
  - Sets on any BAD code, or on JUMP in ACQ/LOCKED.
  - Cleared only by clr. It stays 1 after recovery to LOCKED.
- Direction reversal (UP followed by DOWN) is legal and does not drop lock.
- lock equals (state==LOCKED), registered.

Decomposition:
- Shared package:
  - Johnson-to-phase decode constants: 8 legal codes indexed by phase.
  - FSM state encoding: IDLE=2'd0, ACQ=2'd1, LOCKED=2'd2, FAULT=2'd3.
  - Transition-class enum: HOLD, UP, DOWN, JUMP, BAD.
- One natural sub-module, johnson_decode: a combinational 4-bit code -> {valid, phase[2:0]} block, reusable by other consumers of the counter.
- FSM, event generation and counters stay in the top module.

Test Plan:
- Reset, then drive the up sequence 0000,1000,1100,1110,1111,0111,0011,0001 repeated, one code per clk:
  - phase_valid=1 two clk after the first code; phase follows 0..7 two clk delayed.
  - step=1 every cycle from the second code; lock=1 after LOCK_N=4 steps.
  - wrap=1 on 7->0 and cyc_cnt=1 after the first wrap; illegal=0 throughout.
- From LOCKED at phase 3 (1110), drive 1100,1000,0000,0001:
  - dir=0, step each cycle, lock stays 1.
  - wrap pulses on 0->7; cyc_cnt decrements by 1.
- From LOCKED at phase 2, drive 1010 (illegal code):
  - Two clk later illegal=1, lock=0, phase_valid=0, phase stays 2, no step.
  - Then drive 1110 followed by 4 up steps: ACQ, then lock=1 again; illegal remains 1.
- From LOCKED at phase 1, drive 1111 (legal, jump of +3):
  - FAULT, illegal=1, no step/wrap.
- Hold jq=1100 for 10 clk while in LOCKED:
  - step=0, lock stays 1, phase=2.
- Assert clr asynchronously mid-sequence, between edges:
  - All outputs return to reset values immediately.
  - After release, the first code gives phase_valid with no step and cyc_cnt=0.
  - Also run 2^CW up wraps and check cyc_cnt rolls 255->0.

Source files
------------

// File: rtl/johnson_phase_monitor_pkg.sv
// Shared definitions for consumers of the 4-bit Johnson up/down counter.
//   - jcode_of(): the legal Johnson code for each phase index 0..7
//   - ST_*: FSM state encoding of the phase monitor (IDLE, ACQ, LOCKED, FAULT)
//   - tclass_t: classification of one sampled transition
package johnson_phase_monitor_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  typedef enum logic [2:0] {
    TC_HOLD = 3'd0,
    TC_UP   = 3'd1,
    TC_DOWN = 3'd2,
    TC_JUMP = 3'd3,
    TC_BAD  = 3'd4
  } tclass_t;

  // Legal Johnson code for a given phase; the twisted ring fills with ones
  // from the MSB, then empties from the MSB.
  function automatic logic [3:0] jcode_of(input logic [2:0] p);
    logic [3:0] c;
    case (p)
      3'd0:    c = 4'b0000;
      3'd1:    c = 4'b1000;
      3'd2:    c = 4'b1100;
      3'd3:    c = 4'b1110;
      3'd4:    c = 4'b1111;
      3'd5:    c = 4'b0111;
      3'd6:    c = 4'b0011;
      default: c = 4'b0001;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/johnson_phase_monitor_decode.sv
// Combinational Johnson decoder: 4-bit code -> {valid, phase[2:0]}.
// Ports:
//   code  in  [3:0] Johnson code, bit 3 = MSB
//   valid out       code is one of the 8 legal codes
//   phase out [2:0] decoded phase index (0 when invalid)
module johnson_decode
  import johnson_phase_monitor_pkg::*;
(
  input  logic [3:0] code,
  output logic       valid,
  output logic [2:0] phase
);

  always_comb begin
    valid = 1'b0;
    phase = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (code == jcode_of(3'(i))) begin
        valid = 1'b1;
        phase = 3'(i);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson phase monitor: samples the counter code, decodes it to a phase,
// classifies each transition and reports step/wrap/direction events, a wrap
// count, lock status and a sticky illegal flag. Two-clock latency from jq to
// the registered outputs (jq -> jq_r -> outputs).
// Ports:
//   clk         in        system clock, rising edge
//   clr         in        asynchronous active-high reset
//   jq          in  [3:0] Johnson code from the counter
//   phase       out [2:0] decoded phase index
//   phase_valid out       phase holds a legally decoded code
//   step        out       one-cycle pulse on a +1/-1 move
//   dir         out       direction of last move (1 = up)
//   wrap        out       one-cycle pulse on 7->0 up or 0->7 down
//   cyc_cnt     out [CW-1:0] wrap count modulo 2^CW
//   lock        out       FSM is in LOCKED
//   illegal     out       sticky: illegal code or illegal jump seen
//   fsm_state   out [1:0] debug view of the FSM state register
module johnson_phase_monitor
  import johnson_phase_monitor_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [3:0]    jq,
  output logic [2:0]    phase,
  output logic          phase_valid,
  output logic          step,
  output logic          dir,
  output logic          wrap,
  output logic [CW-1:0] cyc_cnt,
  output logic          lock,
  output logic          illegal,
  output logic [1:0]    fsm_state
);

  logic [3:0] jq_r;
  logic [1:0] state, state_nx;
  logic [3:0] rc, rc_nx;
  logic       have_prev;

  logic       d_valid;
  logic [2:0] d_phase;
  logic [2:0] delta;
  tclass_t    tclass;
  logic       track;
  logic       is_move;
  logic       is_up;
  logic       wrap_now;

  johnson_decode u_decode (
    .code  (jq_r),
    .valid (d_valid),
    .phase (d_phase)
  );

  // Modulo-8 distance from the registered phase decides the class.
  always_comb begin
    delta = d_phase - phase;
    if (!d_valid)          tclass = TC_BAD;
    else if (delta == 3'd0) tclass = TC_HOLD;
    else if (delta == 3'd1) tclass = TC_UP;
    else if (delta == 3'd7) tclass = TC_DOWN;
    else                   tclass = TC_JUMP;
  end

  // Transitions are only judged against a phase we actually hold; IDLE and
  // FAULT treat any legal code as a fresh load instead.
  assign track    = have_prev && ((state == ST_ACQ) || (state == ST_LOCKED));
  assign is_move  = track && ((tclass == TC_UP) || (tclass == TC_DOWN));
  assign is_up    = (tclass == TC_UP);
  assign wrap_now = is_move && (is_up ? (phase == 3'd7) : (phase == 3'd0));

  always_comb begin
    state_nx = state;
    rc_nx    = rc;
    if (!track) begin
      if (d_valid) begin
        state_nx = ST_ACQ;
        rc_nx    = 4'd0;
      end
    end else begin
      case (tclass)
        TC_UP, TC_DOWN: begin
          if (state == ST_ACQ) begin
            rc_nx = rc + 4'd1;
            if (rc_nx == 4'(LOCK_N)) state_nx = ST_LOCKED;
          end
        end
        TC_JUMP, TC_BAD: begin
          state_nx = ST_FAULT;
          rc_nx    = 4'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      jq_r        <= 4'b0000;
      state       <= ST_IDLE;
      rc          <= 4'd0;
      have_prev   <= 1'b0;
      phase       <= 3'd0;
      phase_valid <= 1'b0;
      step        <= 1'b0;
      dir         <= 1'b1;
      wrap        <= 1'b0;
      cyc_cnt     <= '0;
      lock        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      jq_r  <= jq;
      state <= state_nx;
      rc    <= rc_nx;
      lock  <= (state_nx == ST_LOCKED);
      step  <= is_move;
      wrap  <= wrap_now;

      if (is_move) begin
        phase <= d_phase;
        dir   <= is_up;
      end

      if (wrap_now) begin
        if (is_up) cyc_cnt <= cyc_cnt + CW'(1);
        else       cyc_cnt <= cyc_cnt - CW'(1);
      end

      // Fresh load from IDLE or FAULT: no step, no direction change.
      if (!track && d_valid) begin
        phase       <= d_phase;
        phase_valid <= 1'b1;
        have_prev   <= 1'b1;
      end

      if ((state_nx == ST_FAULT) || (!track && !d_valid)) phase_valid <= 1'b0;

      if ((tclass == TC_BAD) || (track && (tclass == TC_JUMP))) illegal <= 1'b1;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Self-checking bench for johnson_phase_monitor.
// Expected output vectors {phase, phase_valid, step, dir, wrap, cyc_cnt, lock,
// illegal, fsm_state} come from a behavioural model and travel through a
// queue that matches the two-clock pipeline of the design.
module tb_johnson_phase_monitor;

  localparam int LOCK_N = 4;
  localparam int CW     = 8;
  localparam int W      = 19;

  logic          clk;
  logic          clr;
  logic [3:0]    jq;
  logic [2:0]    phase;
  logic          phase_valid;
  logic          step;
  logic          dir;
  logic          wrap;
  logic [CW-1:0] cyc_cnt;
  logic          lock;
  logic          illegal;
  logic [1:0]    fsm_state;

  johnson_phase_monitor #(.LOCK_N(LOCK_N), .CW(CW)) dut (
    .clk         (clk),
    .clr         (clr),
    .jq          (jq),
    .phase       (phase),
    .phase_valid (phase_valid),
    .step        (step),
    .dir         (dir),
    .wrap        (wrap),
    .cyc_cnt     (cyc_cnt),
    .lock        (lock),
    .illegal     (illegal),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  string cur_tag = "init";

  logic [3:0] jtab [0:7];

  // model state
  logic [2:0] m_phase;
  logic       m_pv, m_step, m_dir, m_wrap, m_lock, m_ill, m_have;
  logic [7:0] m_cyc;
  logic [1:0] m_st;
  int         m_rc;

  localparam logic [W-1:0] RESET_VEC = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {phase, phase_valid, step, dir, wrap, cyc_cnt, lock, illegal, fsm_state};
  endfunction

  function automatic logic [W-1:0] model_vec();
    return {m_phase, m_pv, m_step, m_dir, m_wrap, m_cyc, m_lock, m_ill, m_st};
  endfunction

  task automatic model_reset();
    m_phase = 3'd0; m_pv = 1'b0; m_step = 1'b0; m_dir = 1'b1; m_wrap = 1'b0;
    m_cyc = 8'd0; m_lock = 1'b0; m_ill = 1'b0; m_st = 2'd0; m_rc = 0; m_have = 1'b0;
  endtask

  task automatic model_fault();
    m_st = 2'd3; m_pv = 1'b0; m_rc = 0; m_ill = 1'b1;
  endtask

  // Apply one decoded sample to the model (what the DUT does on the edge
  // that sees this code in jq_r).
  task automatic model_apply(input logic [3:0] c);
    int d;
    int delta;
    bit up;
    d = -1;
    for (int i = 0; i < 8; i++) if (jtab[i] == c) d = i;
    m_step = 1'b0;
    m_wrap = 1'b0;
    if (m_st == 2'd0 || m_st == 2'd3) begin
      if (d >= 0) begin
        m_phase = 3'(d); m_pv = 1'b1; m_have = 1'b1; m_rc = 0; m_st = 2'd1;
      end else begin
        m_ill = 1'b1; m_pv = 1'b0;
      end
    end else if (d < 0) begin
      model_fault();
    end else begin
      delta = (d - int'(m_phase) + 8) % 8;
      if (delta == 1 || delta == 7) begin
        up = (delta == 1);
        m_wrap = up ? (m_phase == 3'd7) : (m_phase == 3'd0);
        if (m_wrap) m_cyc = up ? m_cyc + 8'd1 : m_cyc - 8'd1;
        m_step = 1'b1;
        m_dir = up;
        m_phase = 3'(d);
        if (m_st == 2'd1) begin
          m_rc++;
          if (m_rc == LOCK_N) m_st = 2'd2;
        end
      end else if (delta != 0) begin
        model_fault();
      end
    end
    m_lock = (m_st == 2'd2);
  endtask

  // ---------------- driver tasks ----------------
  // Drive one code for one cycle; its expected result is queued now and the
  // DUT result for the code driven one call earlier is compared after the edge.
  task automatic drive(input logic [3:0] c);
    jq = c;
    model_apply(c);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({cur_tag, "_qempty"}, 32'd1, 32'd0);
    end else begin
      check(cur_tag, 32'(dut_vec()), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic drive_phase(input int p);
    drive(jtab[p & 7]);
  endtask

  // Release reset at a falling edge; jq_r holds 0000 out of reset and is
  // consumed by the first edge, so its result is queued first.
  task automatic release_reset();
    @(negedge clk);
    clr = 1'b0;
    model_apply(4'b0000);
    exp_q.push_back(model_vec());
  endtask

  // ---------------- stimulus ----------------
  int cur;
  int r;
  logic [3:0] rc_code;

  initial begin
    jtab[0] = 4'b0000; jtab[1] = 4'b1000; jtab[2] = 4'b1100; jtab[3] = 4'b1110;
    jtab[4] = 4'b1111; jtab[5] = 4'b0111; jtab[6] = 4'b0011; jtab[7] = 4'b0001;

    clr = 1'b1;
    jq  = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", 32'(dut_vec()), 32'(RESET_VEC));
    release_reset();

    // Up sequence twice from reset.
    cur_tag = "up_seq";
    for (int k = 0; k < 16; k++) drive_phase(k % 8);
    check("up_lock", 32'(lock), 32'd1);
    check("up_illegal", 32'(illegal), 32'd0);
    check("up_cyc", 32'(cyc_cnt), 32'd1);

    // Reach phase 3 then run downward across 0 -> 7.
    cur_tag = "down_seq";
    for (int p = 0; p <= 3; p++) drive_phase(p);
    drive(4'b1100); drive(4'b1000); drive(4'b0000); drive(4'b0001);
    drive(4'b0001);
    check("down_dir", 32'(dir), 32'd0);
    check("down_lock", 32'(lock), 32'd1);
    check("down_cyc", 32'(cyc_cnt), 32'd1);

    // Illegal code from phase 2, then recover.
    cur_tag = "bad_code";
    drive_phase(0); drive_phase(1); drive_phase(2);
    drive(4'b1010);
    drive(4'b1110);
    check("bad_illegal", 32'(illegal), 32'd1);
    check("bad_lock", 32'(lock), 32'd0);
    check("bad_pv", 32'(phase_valid), 32'd0);
    check("bad_phase", 32'(phase), 32'd2);
    check("bad_step", 32'(step), 32'd0);
    cur_tag = "recover";
    for (int p = 4; p <= 7; p++) drive_phase(p);
    drive_phase(7);
    check("recover_lock", 32'(lock), 32'd1);
    check("recover_illegal", 32'(illegal), 32'd1);

    // Legal jump +3 from phase 1.
    cur_tag = "jump";
    drive_phase(0); drive_phase(1);
    drive(4'b1111);
    drive(4'b0111);
    check("jump_state", 32'(fsm_state), 32'd3);
    check("jump_step", 32'(step), 32'd0);
    check("jump_wrap", 32'(wrap), 32'd0);
    for (int p = 6; p <= 9; p++) drive_phase(p);
    drive_phase(2);

    // Hold phase 2 for 10 cycles while locked.
    cur_tag = "hold";
    repeat (10) drive(4'b1100);
    check("hold_lock", 32'(lock), 32'd1);
    check("hold_phase", 32'(phase), 32'd2);
    check("hold_step", 32'(step), 32'd0);

    // Random walk with holds, reversals and occasional arbitrary codes.
    cur_tag = "random";
    cur = 2;
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        drive_phase(cur);
      end else if (r <= 5) begin
        cur = (cur + 1) % 8; drive_phase(cur);
      end else if (r <= 8) begin
        cur = (cur + 7) % 8; drive_phase(cur);
      end else begin
        rc_code = 4'($urandom_range(0, 15));
        for (int i = 0; i < 8; i++) if (jtab[i] == rc_code) cur = i;
        drive(rc_code);
      end
    end

    // Asynchronous clear between edges.
    cur_tag = "async_clr";
    #2;
    clr = 1'b1;
    #1;
    check("clr_immediate", 32'(dut_vec()), 32'(RESET_VEC));
    @(posedge clk);
    #1;
    check("clr_held", 32'(dut_vec()), 32'(RESET_VEC));
    exp_q.delete();
    model_reset();
    release_reset();
    cur_tag = "after_clr";
    drive_phase(0);
    drive_phase(0);
    check("after_clr_pv", 32'(phase_valid), 32'd1);
    check("after_clr_step", 32'(step), 32'd0);
    check("after_clr_cyc", 32'(cyc_cnt), 32'd0);

    // 2^CW up wraps: count runs to 255 and rolls to 0.
    cur_tag = "wrap_roll";
    for (int w = 0; w < 255; w++) for (int p = 1; p <= 8; p++) drive_phase(p);
    drive_phase(0);
    check("cyc_255", 32'(cyc_cnt), 32'd255);
    for (int p = 1; p <= 8; p++) drive_phase(p);
    drive_phase(0);
    check("cyc_roll", 32'(cyc_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
